// File: rtl/sm83_bus_ctrl_if.sv
// rtl/sm83_bus_ctrl_if.sv - sequencer strobes, request side and external bus of the SM83 bus controller
interface sm83_bus_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              t1, t2, t3, t4, m1;
  logic              req_rd, req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] dout_o;
  logic              dout_en, rd_o, wr_o, fetch_o;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] opcode_o;
  logic              op_done, busy, aborted, err;

  modport master (
    output t1, t2, t3, t4, m1, req_rd, req_wr, req_addr, req_wdata, din,
    input  addr_o, dout_o, dout_en, rd_o, wr_o, fetch_o, rdata, opcode_o,
           op_done, busy, aborted, err
  );

  modport slave (
    input  t1, t2, t3, t4, m1, req_rd, req_wr, req_addr, req_wdata, din,
    output addr_o, dout_o, dout_en, rd_o, wr_o, fetch_o, rdata, opcode_o,
           op_done, busy, aborted, err
  );
endinterface

// File: rtl/sm83_bus_ctrl.sv
// rtl/sm83_bus_ctrl.sv - turns T1..T4 strobes into one registered external bus transaction per M-cycle
module sm83_bus_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  sm83_bus_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ADDR, ACT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d, rdata_q, rdata_d, opcode_q, opcode_d;
  logic              dout_en_q, dout_en_d, rd_q, rd_d, wr_q, wr_d, fetch_q, fetch_d;
  logic              op_done_q, op_done_d, busy_q, busy_d, aborted_q, aborted_d, err_q, err_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    rdata_d   = rdata_q;
    opcode_d  = opcode_q;
    dout_en_d = dout_en_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    fetch_d   = fetch_q;
    busy_d    = busy_q;
    err_d     = err_q;
    op_done_d = 1'b0;
    aborted_d = 1'b0;

    // t1 always wins: it ends whatever is in flight, then may start a new transaction
    if (bus.t1) begin
      if (state_q == ADDR || state_q == ACT) aborted_d = 1'b1;
      if (state_q != IDLE) begin
        state_d   = IDLE;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        dout_en_d = 1'b0;
        fetch_d   = 1'b0;
        busy_d    = 1'b0;
      end
      if (bus.req_rd || bus.req_wr) begin
        state_d = ADDR;
        addr_d  = bus.req_addr;
        busy_d  = 1'b1;
        wr_d    = 1'b0;
        if (bus.req_wr) begin
          dout_d    = bus.req_wdata;
          dout_en_d = 1'b1;
          rd_d      = 1'b0;
          fetch_d   = 1'b0;
          err_d     = err_q | bus.req_rd;
        end else begin
          dout_en_d = 1'b0;
          rd_d      = 1'b1;
          fetch_d   = bus.m1;
        end
      end
    end else if (bus.t2 && state_q == ADDR) begin
      state_d = ACT;
      wr_d    = dout_en_q;
    end else if (bus.t3 && state_q == ACT) begin
      state_d   = DONE;
      op_done_d = 1'b1;
      // dout_en doubles as the transaction-is-a-write flag
      if (!dout_en_q) begin
        rdata_d = bus.din;
        rd_d    = 1'b0;
        if (fetch_q) opcode_d = bus.din;
      end
    end else if (bus.t4 && state_q == DONE) begin
      state_d   = IDLE;
      wr_d      = 1'b0;
      dout_en_d = 1'b0;
      busy_d    = 1'b0;
      fetch_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      dout_q    <= '0;
      rdata_q   <= '0;
      opcode_q  <= '0;
      dout_en_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      fetch_q   <= 1'b0;
      op_done_q <= 1'b0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rdata_q   <= rdata_d;
      opcode_q  <= opcode_d;
      dout_en_q <= dout_en_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      fetch_q   <= fetch_d;
      op_done_q <= op_done_d;
      busy_q    <= busy_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign bus.addr_o   = addr_q;
  assign bus.dout_o   = dout_q;
  assign bus.dout_en  = dout_en_q;
  assign bus.rd_o     = rd_q;
  assign bus.wr_o     = wr_q;
  assign bus.fetch_o  = fetch_q;
  assign bus.rdata    = rdata_q;
  assign bus.opcode_o = opcode_q;
  assign bus.op_done  = op_done_q;
  assign bus.busy     = busy_q;
  assign bus.aborted  = aborted_q;
  assign bus.err      = err_q;
endmodule

// File: doc/sm83_bus_ctrl.md
Name: sm83_bus_ctrl

Overview:
- Downstream consumer of the SM83 T/M-cycle sequencer.
- Converts one-hot T-state strobes (t1..t4) plus the m1 flag into one external memory transaction per M-cycle: latches the address, drives the rd/wr strobes, drives write data, and captures read data and opcodes.
- Sits between core control (request side) and the external 8-bit bus.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- t1, t2, t3, t4  in  1 each  one-hot T-state strobes from the sequencer.
- m1  in  1  sequencer M1 flag; marks an opcode-fetch cycle.
- req_rd  in  1  read request; sampled only in a T1 cycle.
- req_wr  in  1  write request; sampled only in a T1 cycle.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- din  in  DATA_W  external bus read data.
- addr_o  out  ADDR_W  registered bus address.
- dout_o  out  DATA_W  registered write data.
- dout_en  out  1  write-data drive enable.
- rd_o  out  1  read strobe.
- wr_o  out  1  write strobe.
- fetch_o  out  1  current transaction is an opcode fetch.
- rdata  out  DATA_W  last captured read data.
- opcode_o  out  DATA_W  last fetched opcode.
- op_done  out  1  one-cycle completion pulse.
- busy  out  1  transaction in flight.
- aborted  out  1  one-cycle pulse when a transaction is cut short.
- err  out  1  sticky: simultaneous rd+wr request seen.

Behaviour:
- All outputs are registered and update on posedge clk. "Cycle Tn" means the clock cycle in which tn=1; an action "at edge Tn" takes effect at the posedge that ends cycle Tn.
- Reset (clk edge with reset=1) overrides everything and can land mid-transaction:
  - state := IDLE.
  - addr_o, dout_o, rdata, opcode_o := 0.
  - dout_en, rd_o, wr_o, fetch_o, op_done, busy, aborted, err := 0.
  - No completion pulse is generated for the interrupted transaction.
- FSM states: IDLE, ADDR, ACT, DONE.
  - Transitions: IDLE -(edge T1 with req)-> ADDR -(edge T2)-> ACT -(edge T3)-> DONE -(edge T4)-> IDLE.
  - At edge T1, a new request is accepted from IDLE or DONE.
  - A T-strobe that does not match the expected state (other than t1) leaves the state unchanged.
- Read, accepted at edge T1 with req_rd=1, req_wr=0:
  - At edge T1: addr_o := req_addr; rd_o := 1; busy := 1; fetch_o := m1.
  - At edge T3: rdata := din; opcode_o := din if fetch_o; rd_o := 0; op_done := 1.
  - At edge T4: op_done := 0; busy := 0; fetch_o := 0.
  - Resulting waveform: rd_o high in cycles T2 and T3; op_done high in cycle T4; rdata valid from cycle T4 onward.
- Write, accepted at edge T1 with req_wr=1:
  - At edge T1: addr_o := req_addr; dout_o := req_wdata; dout_en := 1; busy := 1.
  - At edge T2: wr_o := 1.
  - At edge T3: op_done := 1.
  - At edge T4: wr_o := 0; dout_en := 0; op_done := 0; busy := 0.
  - Resulting waveform: wr_o high in cycles T3 and T4; dout_en high in cycles T2–T4.
- No request at edge T1:
  - State stays IDLE.
  - addr_o and dout_o hold their previous values.
  - All strobes stay 0.
- Simultaneous req_rd and req_wr at edge T1:
  - Performed as a write.
  - err := 1 and remains set until reset.
- Requests outside T1 cycles are ignored.
- Abort (sequencer restarted by ncyc): t1=1 while state is ADDR or ACT.
  - At that edge: rd_o, wr_o, dout_en, fetch_o := 0; op_done is not pulsed; aborted := 1 for one cycle.
  - The T1 request present in that same cycle is accepted normally at the same edge (new values override the cleared ones).
- Invariant, for any input sequence including non-one-hot T-strobes:
  - rd_o and wr_o are never both 1.
  - wr_o=1 implies dout_en=1.
- op_done and aborted are never both 1 in the same cycle.

Test Plan:
- Read: T1 with req_rd=1, req_addr=16'hC000, m1=0; din=8'h5A in T3 -> addr_o=C000 from T2; rd_o=1 in T2–T3; rdata=5A and op_done=1 in T4; busy=0 in the following T1.
- Fetch: m1=1, req_rd=1, req_addr=16'h0100, din=8'h3E -> fetch_o=1 in T2–T4; opcode_o=3E and rdata=3E from T4.
- Write: req_wr=1, req_addr=16'hFF80, req_wdata=8'hA7 -> dout_o=A7 and dout_en=1 in T2–T4; wr_o=1 in T3–T4; op_done=1 in T4; all strobes 0 in the next T1.
- Back-to-back plus conflict: read then write in consecutive M-cycles -> no cycle with rd_o=wr_o=1. Then a T1 with req_rd=req_wr=1 -> write performed and err=1, still 1 after 10 idle M-cycles.
- Abort: read accepted, then t1 reasserted in the ACT cycle (ncyc restart) with req_wr=1, req_addr=16'h8000 -> aborted=1 for one cycle; no op_done for the read; the write to 8000 completes normally.
- Reset mid-write: reset=1 in cycle T3 -> next cycle wr_o=0, dout_en=0, busy=0, addr_o=0; the following T1 read completes normally.
